rom_arbiter: RTL
================

// Module: rom_arbiter
// PURPOSE
//  Shares one synchronous-read ROM (1-cycle read latency, registered q) among
//  NUM_REQ requesters. Round-robin arbitration with per-requester bursts of
//  sequential addresses; returns read data tagged to the owning requester.
//  Sits between the ROM instance and its clients (e.g. sprite/font/LUT readers).
// PARAMETERS
//  NUM_REQ    2  number of requesters, legal range 2..4
//  ADDR_WIDTH 9  ROM address width; must match the ROM instance
//  DATA_WIDTH 8  ROM data width; must match the ROM instance
//  LEN_WIDTH  4  burst length field width; len=n requests n+1 words
// PORTS
//  clk       in   1                    single clock, all logic on posedge
//  rst       in   1                    synchronous, active-high reset
//  req       in   NUM_REQ              request per requester, level
//  addr      in   NUM_REQ*ADDR_WIDTH   start address, requester i at [i*AW +: AW]
//  len       in   NUM_REQ*LEN_WIDTH    burst length-1, requester i at [i*LW +: LW]
//  gnt       out  NUM_REQ              one-hot 1-cycle accept pulse (combinational)
//  rvalid    out  NUM_REQ              one-hot: rdata valid for requester i
//  rlast     out  1                    with rvalid: final word of burst
//  rdata     out  DATA_WIDTH           = rom_q (direct pass-through)
//  busy      out  1                    1 while in BURST state
//  rom_raddr out  ADDR_WIDTH           address to ROM raddr (combinational)
//  rom_q     in   DATA_WIDTH           ROM q
// BEHAVIOUR
//  - State: IDLE/BURST, owner index, next address cur_addr, remaining count,
//    round-robin pointer ptr (highest-priority requester).
//  - Reset (sync): state=IDLE, ptr=0, rvalid=0, rlast=0, busy=0; gnt=0 and
//    rom_raddr=0 forced combinationally while rst=1. rdata follows rom_q.
//  - IDLE, some req=1: winner = first set req scanning ptr, ptr+1, .. mod NUM_REQ.
//    Same cycle: gnt[winner]=1, rom_raddr=addr[winner] (word 0 issued),
//    owner<=winner, cur_addr<=addr+1, remaining<=len, ptr<=winner+1 mod NUM_REQ.
//    len==0 -> stay IDLE (single-word burst); else -> BURST.
//  - IDLE, no req: rom_raddr = 0, no issue, ptr unchanged.
//  - BURST: each cycle issue rom_raddr=cur_addr, cur_addr++, remaining--;
//    issuing the word with remaining==1 -> IDLE. req/addr/len ignored in BURST.
//  - Addresses wrap modulo 2^ADDR_WIDTH (last address -> 0), no error.
//  - Latency: word issued in cycle N -> rvalid[owner]=1 and rdata valid in N+1.
//    rlast=1 in N+1 iff word N was the burst's final word. rvalid/rlast registered.
//  - Back-to-back: IDLE immediately follows last issue, so the next grant issues
//    the cycle after the final BURST issue: zero bubble, full ROM throughput.
//  - Requester must hold req, addr, len stable until it sees gnt; addr/len are
//    sampled only in the gnt cycle. req still high the cycle after gnt is a new
//    request.
//  - req dropped before gnt: request withdrawn, no side effect.
//  - Reset mid-burst: burst abandoned; rvalid/rlast low from the first cycle
//    after the reset edge; no further words for the old owner.
// TESTING
//  1. rst, then req[0]=1 addr0=0x010 len0=0 -> gnt[0] cycle 0, rom_raddr=0x010;
//     cycle 1 rvalid=01, rlast=1, rdata=mem[0x010].
//  2. req[0] addr0=0x1FE len0=3 -> rom_raddr 1FE,1FF,000,001 over 4 cycles;
//     rvalid[0] cycles 1-4, rlast only on cycle 4; busy high cycles 1-3.
//  3. req=11 held, both len=0 -> gnt 01,10,01,10..., first grant to req 0
//     after reset; rvalid follows one cycle later.
//  4. req[0] len=2 granted; req[1] raised mid-burst -> gnt[1] in the cycle right
//     after req 0's third issue; rvalid contiguous 01,01,01,10.
//  5. rst pulsed during cycle 2 of a len=7 burst -> rvalid=0, busy=0 after edge;
//     then req=11 together -> req 0 wins (ptr reset to 0).
//  6. NUM_REQ=3, ptr=2, req=011 -> gnt=001; then req=110 -> gnt=010.

Source files
------------

// File: rtl/rom_arbiter.sv
// ============================================================================
//  Module      : rom_arbiter
//  Description : Round-robin burst arbiter sharing one synchronous-read ROM
//                (1-cycle latency) among NUM_REQ requesters; tags read data
//                back to the owning requester.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  len,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic                          rlast,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         rom_raddr,
    input  logic [DATA_WIDTH-1:0]         rom_q
);

    localparam int                 c_IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [c_IDX_W:0]   c_NUM   = (c_IDX_W+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_IDX_W-1:0]     r_owner;
    logic [c_IDX_W-1:0]     r_ptr;
    logic [ADDR_WIDTH-1:0]  r_cur_addr;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [NUM_REQ-1:0]     r_rvalid;
    logic                   r_rlast;

    logic [ADDR_WIDTH-1:0]  w_addr_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]   w_len_arr  [NUM_REQ];
    logic                   w_found;
    logic [c_IDX_W-1:0]     w_winner;
    logic [c_IDX_W-1:0]     w_idx;
    logic                   w_issue;
    logic                   w_last;
    logic                   w_load;
    logic [c_IDX_W-1:0]     w_issue_owner;
    logic [ADDR_WIDTH-1:0]  w_raddr;
    logic [NUM_REQ-1:0]     w_gnt;

    // Index addition modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [c_IDX_W-1:0] f_mod_add(
        input logic [c_IDX_W-1:0] a,
        input logic [c_IDX_W-1:0] b
    );
        logic [c_IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_NUM) begin
            s = s - c_NUM;
        end
        return s[c_IDX_W-1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_len_arr[gi]  = len[gi*LEN_WIDTH +: LEN_WIDTH];
        end
    endgenerate

    // First asserted request scanning from the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = f_mod_add(r_ptr, c_IDX_W'(k));
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        w_last        = 1'b0;
        w_load        = 1'b0;
        w_issue_owner = r_owner;
        w_raddr       = '0;
        w_gnt         = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_gnt         = c_ONE << w_winner;
                        w_raddr       = w_addr_arr[w_winner];
                        w_issue       = 1'b1;
                        w_load        = 1'b1;
                        w_issue_owner = w_winner;
                        if (w_len_arr[w_winner] == '0) begin
                            w_last = 1'b1;
                        end else begin
                            w_state_nxt = ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    w_raddr = r_cur_addr;
                    w_issue = 1'b1;
                    if (r_remaining == LEN_WIDTH'(1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_rvalid    <= '0;
            r_rlast     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= w_issue ? (c_ONE << w_issue_owner) : '0;
            r_rlast  <= w_last;
            if (w_load) begin
                r_owner     <= w_winner;
                r_cur_addr  <= w_addr_arr[w_winner] + ADDR_WIDTH'(1);
                r_remaining <= w_len_arr[w_winner];
                r_ptr       <= f_mod_add(w_winner, c_IDX_W'(1));
            end else if (r_state == ST_BURST) begin
                // Address counter wraps naturally past the top of the ROM.
                r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
        end
    end

    assign gnt       = w_gnt;
    assign rom_raddr = w_raddr;
    assign rvalid    = r_rvalid;
    assign rlast     = r_rlast;
    assign busy      = (r_state == ST_BURST);
    assign rdata     = rom_q;

endmodule

`default_nettype wire
